// File: rtl/reward_pkg.sv
// Shared type codes and default effect durations for the reward effect timer.
package reward_pkg;

    // Pickup type codes as produced by reward_logic
    localparam logic [2:0] RW_INVINCIBLE = 3'd0;
    localparam logic [2:0] RW_ADDTIME    = 3'd1;
    localparam logic [2:0] RW_FASTER     = 3'd2;
    localparam logic [2:0] RW_FROZEN     = 3'd3;
    localparam logic [2:0] RW_LASER      = 3'd4;

    // Default durations in 4 Hz ticks
    localparam int unsigned DEF_DUR_INVINCIBLE = 40;
    localparam int unsigned DEF_DUR_FASTER     = 40;
    localparam int unsigned DEF_DUR_FROZEN     = 20;
    localparam int unsigned DEF_DUR_LASER      = 12;

    localparam int unsigned DEF_CNT_W = 8;

    // True for pickup types that load a timed effect
    function automatic logic is_timed(input logic [2:0] t);
        return (t == RW_INVINCIBLE) || (t == RW_FASTER) ||
               (t == RW_FROZEN)     || (t == RW_LASER);
    endfunction

    // True for reserved pickup type codes
    function automatic logic is_reserved(input logic [2:0] t);
        return t > RW_LASER;
    endfunction

endpackage

// File: rtl/reward_effect_counter.sv
// One timed effect: loadable down-counter in 4 Hz ticks with a registered
// active level. Priority is clear > load > decrement; never wraps below 0.
module reward_effect_counter #(
    parameter int unsigned DUR   = 40,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             tick,
    input  logic             enable,
    output logic [CNT_W-1:0] cnt,
    output logic             active
);

    logic [CNT_W-1:0] cnt_next;

    // Next count: clear beats load beats tick decrement
    always_comb begin
        cnt_next = cnt;
        if (clear) begin
            cnt_next = '0;
        end else if (enable && load) begin
            cnt_next = CNT_W'(DUR);
        end else if (enable && tick && (cnt != '0)) begin
            cnt_next = cnt - 1'b1;
        end
    end

    // Count register; active is registered from the next count so it always equals (cnt != 0)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            active <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            active <= (cnt_next != '0);
        end
    end

endmodule

// File: rtl/reward_effect_timer.sv
// Turns reward pickup strobes into timed effect levels, an add-time pulse,
// an error pulse for reserved types, and remaining-time status for display.
module reward_effect_timer
    import reward_pkg::*;
#(
    parameter int unsigned DUR_INVINCIBLE = DEF_DUR_INVINCIBLE,
    parameter int unsigned DUR_FASTER     = DEF_DUR_FASTER,
    parameter int unsigned DUR_FROZEN     = DEF_DUR_FROZEN,
    parameter int unsigned DUR_LASER      = DEF_DUR_LASER,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_4Hz,
    input  logic             enable,
    input  logic             clear,
    input  logic             pickup_valid,
    input  logic [2:0]       pickup_type,
    output logic             reward_invincible,
    output logic             reward_faster,
    output logic             reward_frozen,
    output logic             reward_laser,
    output logic             reward_addtime,
    output logic             pickup_error,
    output logic [CNT_W-1:0] last_remaining,
    output logic [2:0]       last_type
);

    logic sync_1, sync_q, edge_q, tick;
    logic load_inv, load_fast, load_frz, load_las;
    logic [CNT_W-1:0] cnt_inv, cnt_fast, cnt_frz, cnt_las;

    // Two-flop synchroniser for clk_4Hz followed by an edge register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_1 <= clk_4Hz;
            sync_q <= sync_1;
            edge_q <= sync_q;
        end
    end

    // Rising-edge detect of the synchronised slow clock and pickup type decode
    always_comb begin
        tick      = sync_q & ~edge_q;
        load_inv  = pickup_valid && (pickup_type == RW_INVINCIBLE);
        load_fast = pickup_valid && (pickup_type == RW_FASTER);
        load_frz  = pickup_valid && (pickup_type == RW_FROZEN);
        load_las  = pickup_valid && (pickup_type == RW_LASER);
    end

    reward_effect_counter #(.DUR(DUR_INVINCIBLE), .CNT_W(CNT_W)) u_cnt_invincible (
        .clk(clk), .rst(rst), .clear(clear), .load(load_inv), .tick(tick),
        .enable(enable), .cnt(cnt_inv), .active(reward_invincible)
    );

    reward_effect_counter #(.DUR(DUR_FASTER), .CNT_W(CNT_W)) u_cnt_faster (
        .clk(clk), .rst(rst), .clear(clear), .load(load_fast), .tick(tick),
        .enable(enable), .cnt(cnt_fast), .active(reward_faster)
    );

    reward_effect_counter #(.DUR(DUR_FROZEN), .CNT_W(CNT_W)) u_cnt_frozen (
        .clk(clk), .rst(rst), .clear(clear), .load(load_frz), .tick(tick),
        .enable(enable), .cnt(cnt_frz), .active(reward_frozen)
    );

    reward_effect_counter #(.DUR(DUR_LASER), .CNT_W(CNT_W)) u_cnt_laser (
        .clk(clk), .rst(rst), .clear(clear), .load(load_las), .tick(tick),
        .enable(enable), .cnt(cnt_las), .active(reward_laser)
    );

    // One-cycle add-time/error pulses and tracking of the last loaded timed effect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reward_addtime <= 1'b0;
            pickup_error   <= 1'b0;
            last_type      <= RW_INVINCIBLE;
        end else begin
            reward_addtime <= enable && pickup_valid && (pickup_type == RW_ADDTIME) && !clear;
            pickup_error   <= enable && pickup_valid && is_reserved(pickup_type);
            if (clear) begin
                last_type <= RW_INVINCIBLE;
            end else if (enable && pickup_valid && is_timed(pickup_type)) begin
                last_type <= pickup_type;
            end
        end
    end

    // Remaining-time status follows whichever counter last_type selects
    always_comb begin
        last_remaining = '0;
        case (last_type)
            RW_INVINCIBLE: last_remaining = cnt_inv;
            RW_FASTER:     last_remaining = cnt_fast;
            RW_FROZEN:     last_remaining = cnt_frz;
            RW_LASER:      last_remaining = cnt_las;
            default:       last_remaining = '0;
        endcase
    end

endmodule

// File: tb/tb_reward_effect_timer.sv
// Self-checking bench for reward_effect_timer: a tick-level effect model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_reward_effect_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_4Hz = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic       pickup_valid = 1'b0;
    logic [2:0] pickup_type = 3'd0;
    logic       reward_invincible, reward_faster, reward_frozen, reward_laser;
    logic       reward_addtime, pickup_error;
    logic [7:0] last_remaining;
    logic [2:0] last_type;

    int checks = 0;
    int errors = 0;
    int fail_lines = 0;

    reward_effect_timer #(
        .DUR_INVINCIBLE(40), .DUR_FASTER(40), .DUR_FROZEN(20), .DUR_LASER(12), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .clk_4Hz(clk_4Hz), .enable(enable), .clear(clear),
        .pickup_valid(pickup_valid), .pickup_type(pickup_type),
        .reward_invincible(reward_invincible), .reward_faster(reward_faster),
        .reward_frozen(reward_frozen), .reward_laser(reward_laser),
        .reward_addtime(reward_addtime), .pickup_error(pickup_error),
        .last_remaining(last_remaining), .last_type(last_type)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Remaining ticks per pickup type (index 1 unused); a tick applies at the
    // clock edge two edges after the edge that first saw clk_4Hz high.
    int         m_cnt [5];
    logic [2:0] m_last;
    logic       m_add, m_err;
    logic       h1, h2, h3;

    function automatic int dur_of(input int t);
        case (t)
            0: return 40;
            2: return 40;
            3: return 20;
            4: return 12;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < 5; t++) m_cnt[t] <= 0;
            m_last <= 3'd0;
            m_add  <= 1'b0;
            m_err  <= 1'b0;
            h1 <= 1'b0; h2 <= 1'b0; h3 <= 1'b0;
        end else begin
            h1 <= clk_4Hz; h2 <= h1; h3 <= h2;
            m_add <= enable && pickup_valid && (pickup_type == 3'd1) && !clear;
            m_err <= enable && pickup_valid && (pickup_type >= 3'd5);
            for (int t = 0; t < 5; t++) begin
                if (t != 1) begin
                    if (clear) m_cnt[t] <= 0;
                    else if (enable && pickup_valid && (int'(pickup_type) == t)) m_cnt[t] <= dur_of(t);
                    else if (enable && h2 && !h3 && m_cnt[t] > 0) m_cnt[t] <= m_cnt[t] - 1;
                end
            end
            if (clear) m_last <= 3'd0;
            else if (enable && pickup_valid && pickup_type != 3'd1 && pickup_type < 3'd5)
                m_last <= pickup_type;
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            if (fail_lines < 40) begin
                fail_lines++;
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
            end
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            check("invincible", int'(reward_invincible), int'(m_cnt[0] != 0));
            check("faster",     int'(reward_faster),     int'(m_cnt[2] != 0));
            check("frozen",     int'(reward_frozen),     int'(m_cnt[3] != 0));
            check("laser",      int'(reward_laser),      int'(m_cnt[4] != 0));
            check("addtime",    int'(reward_addtime),    int'(m_add));
            check("error",      int'(pickup_error),      int'(m_err));
            check("last_type",  int'(last_type),         int'(m_last));
            check("last_rem",   int'(last_remaining),    m_cnt[m_last]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One slow-clock period: 4 cycles high, 4 low; its tick lands inside the period
    task automatic periods(input int n);
        for (int i = 0; i < n; i++) begin
            clk_4Hz = 1'b1; cyc(4);
            clk_4Hz = 1'b0; cyc(4);
        end
    endtask

    task automatic pick(input logic [2:0] t);
        pickup_valid = 1'b1;
        pickup_type  = t;
        @(negedge clk);
        pickup_valid = 1'b0;
    endtask

    int addtime_seen;

    initial begin
        addtime_seen = 0;
        cyc(3);
        check("rst_inv", int'(reward_invincible), 0);
        check("rst_rem", int'(last_remaining), 0);
        check("rst_type", int'(last_type), 0);
        rst = 1'b0;
        enable = 1'b1;
        cyc(2);

        // Idle: ten slow periods, no pickups
        for (int i = 0; i < 10; i++) begin
            periods(1);
            addtime_seen += int'(reward_addtime) + int'(pickup_error);
        end
        check("idle_levels", int'({reward_invincible, reward_faster, reward_frozen, reward_laser}), 0);
        check("idle_pulses", addtime_seen, 0);

        // Frozen: 20 ticks
        pick(3'd3);
        check("frz_type", int'(last_type), 3);
        check("frz_load", int'(last_remaining), 20);
        periods(19);
        check("frz_19", int'(last_remaining), 1);
        check("frz_19_lvl", int'(reward_frozen), 1);
        periods(1);
        check("frz_end", int'(reward_frozen), 0);
        check("frz_end_rem", int'(last_remaining), 0);

        // Laser with reload after 5 ticks
        pick(3'd4);
        check("las_load", int'(last_remaining), 12);
        periods(5);
        check("las_5", int'(last_remaining), 7);
        pick(3'd4);
        check("las_reload", int'(last_remaining), 12);
        periods(11);
        check("las_11", int'(reward_laser), 1);
        check("las_11_rem", int'(last_remaining), 1);
        periods(1);
        check("las_end", int'(reward_laser), 0);

        // Faster pickup in the same cycle as a tick: load wins
        clk_4Hz = 1'b1;
        cyc(2);
        pick(3'd2);
        check("coinc_load", int'(last_remaining), 40);
        cyc(2);
        clk_4Hz = 1'b0;
        cyc(4);
        check("coinc_hold", int'(last_remaining), 40);

        // Addtime pulse, reserved-type error pulse
        pick(3'd1);
        check("add_pulse", int'(reward_addtime), 1);
        check("add_keep_type", int'(last_type), 2);
        cyc(1);
        check("add_once", int'(reward_addtime), 0);
        pick(3'd6);
        check("err_pulse", int'(pickup_error), 1);
        check("err_keep_rem", int'(last_remaining), 40);
        cyc(1);
        check("err_once", int'(pickup_error), 0);

        // Pickups while disabled are dropped
        enable = 1'b0;
        pick(3'd1);
        check("dis_add", int'(reward_addtime), 0);
        enable = 1'b1;
        cyc(1);

        // Invincible to 25, freeze across 8 ticks, then clear beats load
        pick(3'd0);
        check("inv_load", int'(last_remaining), 40);
        periods(15);
        check("inv_25", int'(last_remaining), 25);
        enable = 1'b0;
        periods(8);
        check("inv_frozen", int'(last_remaining), 25);
        check("inv_frozen_lvl", int'(reward_invincible), 1);
        enable = 1'b1;
        cyc(1);
        clear = 1'b1;
        pick(3'd0);
        clear = 1'b0;
        check("clr_inv", int'(reward_invincible), 0);
        check("clr_fast", int'(reward_faster), 0);
        check("clr_rem", int'(last_remaining), 0);
        check("clr_type", int'(last_type), 0);

        // Asynchronous reset mid-effect
        pick(3'd4);
        periods(2);
        check("pre_rst", int'(last_remaining), 10);
        #3 rst = 1'b1;
        #1;
        check("arst_levels", int'({reward_invincible, reward_faster, reward_frozen, reward_laser}), 0);
        check("arst_rem", int'(last_remaining), 0);
        check("arst_type", int'(last_type), 4'd0);
        cyc(2);
        rst = 1'b0;
        pick(3'd3);
        periods(3);
        check("post_rst", int'(last_remaining), 17);

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reward_effect_timer.md
Name: reward_effect_timer

Overview:
- Sits directly downstream of reward_logic. It consumes reward pickup events and turns them into timed effect levels for the tank, enemy and laser logic.
- Also emits a one-shot add-time pulse for the game timer, plus remaining-time status for the seven-segment display.
- Runs on clk_100M. Time is measured in rising edges of the slow clk_4Hz signal, which the block samples as data and never uses as a clock.

Parameters:
- DUR_INVINCIBLE, 40, invincible duration in 4 Hz ticks (10 s)
- DUR_FASTER, 40, faster-fire duration in ticks
- DUR_FROZEN, 20, enemy-frozen duration in ticks
- DUR_LASER, 12, laser duration in ticks
- CNT_W, 8, counter width; every DUR_* value must be <= 2^CNT_W-1

Ports:
- clk, in, 1, system clock (clk_100M)
- rst, in, 1, asynchronous active-high reset
- clk_4Hz, in, 1, slow tick level, asynchronous to clk; synchronised internally
- enable, in, 1, 1 = game running; 0 = freeze all counters and ignore pickups
- clear, in, 1, synchronous clear of all effects (new game / game over)
- pickup_valid, in, 1, one-cycle pickup strobe from reward_logic
- pickup_type, in, 3, 0 invincible, 1 addtime, 2 faster, 3 frozen, 4 laser, 5-7 reserved
- reward_invincible, out, 1, effect active level
- reward_faster, out, 1, effect active level
- reward_frozen, out, 1, effect active level
- reward_laser, out, 1, effect active level
- reward_addtime, out, 1, one-cycle pulse per addtime pickup
- pickup_error, out, 1, one-cycle pulse when pickup_type is 5-7
- last_remaining, out, CNT_W, remaining ticks of the most recently loaded timed effect
- last_type, out, 3, type code of the most recently loaded timed effect

Behaviour:
- Reset (async, rst=1):
  - all four counters = 0, all outputs = 0
  - last_type = 0, last_remaining = 0
  - synchroniser flops = 0
- Tick generation:
  - clk_4Hz passes through a 2-flop synchroniser, then an edge register.
  - tick = sync_q & ~edge_q, which is a one-cycle pulse.
  - A rising edge of clk_4Hz produces tick 2-3 clk cycles later, and exactly one tick per edge.
- Per-effect counter cnt, with priority clear > load > decrement:
  - clear=1: cnt <= 0.
  - Load: enable & pickup_valid & matching type gives cnt <= DUR. A reload while active restarts from DUR and does not accumulate.
  - Decrement: enable & tick & cnt != 0 gives cnt <= cnt-1. A counter at 0 never wraps.
  - Load and tick in the same cycle: load wins, so cnt = DUR, not DUR-1.
- Effect outputs:
  - Each reward_* level is registered, equal to (cnt != 0).
  - Latency: a pickup in cycle N gives the output high in cycle N+1.
  - Expiry: when the tick takes cnt from 1 to 0 in cycle M, the output goes low in cycle M+1.
  - An effect lasts exactly DUR ticks, with a +0/-1 tick phase error that depends on pickup time relative to the tick.
- enable=0:
  - counters hold their value and outputs hold their level
  - pickups are dropped, so reward_addtime and pickup_error stay 0
  - ticks that occur while disabled are lost, not queued
- reward_addtime: registered; goes high for one cycle at N+1 after an enabled addtime pickup. It is not affected by clear unless clear is asserted in cycle N.
- pickup_error: registered one-cycle pulse for an enabled pickup with type 5-7. No counter changes.
- last_type / last_remaining:
  - An enabled timed pickup (type 0, 2, 3 or 4) updates last_type.
  - last_remaining tracks the counter selected by last_type every cycle.
  - clear returns both to 0.
- Reset asserted mid-effect: all state is lost immediately. After deassertion, ticks restart cleanly; the synchroniser zero state means no spurious tick is produced.
- Only one pickup can arrive per cycle, because pickup_type is single-valued.

Decomposition:
- Package reward_pkg holds:
  - localparams for the type codes RW_INVINCIBLE=0, RW_ADDTIME=1, RW_FASTER=2, RW_FROZEN=3, RW_LASER=4
  - the default durations
  - the CNT_W default
- Sub-module reward_effect_counter (parameters DUR, CNT_W):
  - ports: clk, rst, clear, load, tick, enable, cnt, active
  - instantiated four times
  - the top level holds the tick synchroniser, type decode, addtime/error pulses and last_* mux.

Test Plan:
- Reset release, clk_4Hz toggling 10 periods, no pickups: all reward_* = 0, last_remaining = 0, no reward_addtime or pickup_error pulse.
- Frozen pickup (type 3) with DUR_FROZEN = 20:
  - reward_frozen rises at the next clk and stays high for exactly 20 ticks, then goes low one cycle after the 20th tick.
  - last_type = 3; last_remaining counts 20 down to 0.
- Laser pickup, then a re-pickup after 5 ticks: the counter reloads to 12. Total high time is 17 ticks and the value never exceeds 12.
- Pickup strobe coincident with a tick cycle (force a clk_4Hz edge 2 cycles earlier): cnt = DUR after that cycle, not DUR-1.
- Addtime pickup gives exactly one reward_addtime pulse at N+1 and no level change. Type 6 gives one pickup_error pulse and no other change.
- Invincible active at cnt = 25:
  - enable=0 across 8 ticks: cnt stays 25.
  - clear=1 together with a type 0 pickup: cnt = 0 and reward_invincible low next cycle.
  - Async rst mid-effect: all outputs 0 immediately.
